// File: rtl/vga_fb_pkg.sv
// ============================================================================
// Module      : vga_fb_pkg
// Description : Shared opcodes, FSM state encoding and default geometry for
//               the double-buffered VGA framebuffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_fb_pkg;

    localparam int unsigned C_DEF_WIDTH  = 10;
    localparam int unsigned C_DEF_HEIGHT = 10;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_WRITE   = 3'd1;
    localparam logic [2:0] OP_CLEAR   = 3'd2;
    localparam logic [2:0] OP_FILL    = 3'd3;
    localparam logic [2:0] OP_SCROLL  = 3'd4;
    localparam logic [2:0] OP_PRESENT = 3'd5;
    localparam logic [2:0] OP_COPY    = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ROWOP     = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } fb_state_t;

endpackage

`default_nettype wire

// File: rtl/vga_fb_row_unit.sv
// ============================================================================
// Module      : vga_fb_row_unit
// Description : Combinational next value of one back-buffer row for the
//               whole-buffer row operations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_fb_row_unit
    import vga_fb_pkg::*;
#(
    parameter int unsigned WIDTH = C_DEF_WIDTH
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_cur_row,
    input  logic [WIDTH-1:0] i_next_row,
    input  logic [WIDTH-1:0] i_front_row,
    input  logic             i_last_row,
    output logic [WIDTH-1:0] o_new_row
);

    always_comb begin
        o_new_row = i_cur_row;
        case (i_op)
            OP_CLEAR:  o_new_row = '0;
            OP_FILL:   o_new_row = '1;
            // Bottom row has nothing below it to pull up, so it blanks.
            OP_SCROLL: o_new_row = i_last_row ? '0 : i_next_row;
            OP_COPY:   o_new_row = i_front_row;
            default:   o_new_row = i_cur_row;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/vga_framebuffer.sv
// ============================================================================
// Module      : vga_framebuffer
// Description : Double-buffered monochrome framebuffer; CPU edits the back
//               buffer, PRESENT swaps it to the front at the next frame start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_framebuffer
    import vga_fb_pkg::*;
#(
    parameter int unsigned WIDTH  = C_DEF_WIDTH,
    parameter int unsigned HEIGHT = C_DEF_HEIGHT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_op,
    input  logic [3:0]                cmd_x,
    input  logic [3:0]                cmd_y,
    input  logic                      cmd_data,
    input  logic                      frame_start,
    output logic [WIDTH*HEIGHT-1:0]   video_memory,
    output logic                      busy,
    output logic                      swap_pending,
    output logic                      cmd_err
);

    localparam int unsigned   ROW_W      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [ROW_W-1:0] C_LAST_ROW = ROW_W'(HEIGHT - 1);

    fb_state_t        r_state;
    fb_state_t        w_state_nxt;
    logic [2:0]       r_op;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] w_row_nxt_idx;
    logic             r_err;
    logic [WIDTH-1:0] r_back  [HEIGHT];
    logic [WIDTH-1:0] r_front [HEIGHT];

    logic             w_accept;
    logic             w_last_row;
    logic             w_wr_in_range;
    logic             w_is_rowop;
    logic [WIDTH-1:0] w_new_row;

    assign cmd_ready     = !rst && (r_state == ST_IDLE);
    assign busy          = !rst && (r_state != ST_IDLE);
    assign swap_pending  = !rst && (r_state == ST_WAIT_SWAP);
    assign cmd_err       = r_err;

    assign w_accept      = cmd_valid && cmd_ready;
    assign w_last_row    = (r_row == C_LAST_ROW);
    assign w_row_nxt_idx = w_last_row ? r_row : r_row + 1'b1;
    assign w_wr_in_range = (32'(cmd_x) < WIDTH) && (32'(cmd_y) < HEIGHT);
    assign w_is_rowop    = (cmd_op == OP_CLEAR) || (cmd_op == OP_FILL) ||
                           (cmd_op == OP_SCROLL) || (cmd_op == OP_COPY);

    vga_fb_row_unit #(
        .WIDTH (WIDTH)
    ) u_row_unit (
        .i_op        (r_op),
        .i_cur_row   (r_back[r_row]),
        .i_next_row  (r_back[w_row_nxt_idx]),
        .i_front_row (r_front[r_row]),
        .i_last_row  (w_last_row),
        .o_new_row   (w_new_row)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_rowop) begin
                        w_state_nxt = ST_ROWOP;
                    end else if (cmd_op == OP_PRESENT) begin
                        w_state_nxt = ST_WAIT_SWAP;
                    end
                end
            end
            ST_ROWOP: begin
                if (w_last_row) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_SWAP: begin
                if (frame_start) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_row   <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < int'(HEIGHT); i++) begin
                r_back[i]  <= '0;
                r_front[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (cmd_op == OP_WRITE)) begin
                        if (w_wr_in_range) begin
                            r_back[cmd_y][cmd_x] <= cmd_data;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    if (w_accept && w_is_rowop) begin
                        r_op  <= cmd_op;
                        r_row <= '0;
                    end
                end
                ST_ROWOP: begin
                    r_back[r_row] <= w_new_row;
                    r_row         <= w_last_row ? '0 : r_row + 1'b1;
                end
                ST_WAIT_SWAP: begin
                    // Whole-frame copy in one edge so the display never tears.
                    if (frame_start) begin
                        r_front <= r_back;
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < int'(HEIGHT); g++) begin : g_rows
            assign video_memory[g*WIDTH +: WIDTH] = r_front[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_vga_framebuffer.sv
// ============================================================================
// Module      : tb_vga_framebuffer
// Description : Self-checking bench for vga_framebuffer using a vector table,
//               a pixel-level reference model and a swap scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_framebuffer;
    import vga_fb_pkg::*;

    localparam int W = 10;
    localparam int H = 10;
    localparam int N = W * H;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [2:0]   cmd_op = 3'd0;
    logic [3:0]   cmd_x = 4'd0;
    logic [3:0]   cmd_y = 4'd0;
    logic         cmd_data = 1'b0;
    logic         frame_start = 1'b0;
    logic         cmd_ready;
    logic         busy;
    logic         swap_pending;
    logic         cmd_err;
    logic [N-1:0] video_memory;

    vga_framebuffer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .cmd_data     (cmd_data),
        .frame_start  (frame_start),
        .video_memory (video_memory),
        .busy         (busy),
        .swap_pending (swap_pending),
        .cmd_err      (cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [3:0] x;
        logic [3:0] y;
        logic       d;
        logic       exp_err;
        int         exp_busy;
        logic       swap;
    } vec_t;

    vec_t         tbl[$];
    int           n_vec = 0;
    int           n_miss = 0;
    logic [N-1:0] m_back = '0;
    logic [N-1:0] m_front = '0;
    logic [N-1:0] sb[$];

    function automatic vec_t mk(input logic [2:0] op, input int x, input int y,
                                input logic d, input logic err, input int bsy,
                                input logic swp);
        vec_t v;
        v.op = op; v.x = 4'(x); v.y = 4'(y); v.d = d;
        v.exp_err = err; v.exp_busy = bsy; v.swap = swp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_apply(input logic [2:0] op, input logic [3:0] x,
                               input logic [3:0] y, input logic d);
        case (op)
            OP_WRITE:  if (x < 4'(W) && y < 4'(H)) m_back[int'(y)*W + int'(x)] = d;
            OP_CLEAR:  m_back = '0;
            OP_FILL:   m_back = '1;
            OP_SCROLL: m_back = m_back >> W;
            OP_COPY:   m_back = m_front;
            default: ;
        endcase
    endtask

    // Returns at the falling edge following the acceptance edge.
    task automatic issue(input logic [2:0] op, input logic [3:0] x,
                         input logic [3:0] y, input logic d);
        int t = 0;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_vec++; n_miss++;
            $display("FAIL ready_timeout: got cmd_ready=0 expected 1 within 100 cycles");
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_data = d;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_swap(input string name);
        logic [N-1:0] e;
        issue(OP_PRESENT, 4'd0, 4'd0, 1'b0);
        sb.push_back(m_back);
        chk({name, "_pending"}, swap_pending, 1'b1);
        chk({name, "_busy"}, busy, 1'b1);
        chk({name, "_vm_hold"}, video_memory, m_front);
        frame_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_start = 1'b0;
        e = sb.pop_front();
        chk({name, "_vm"}, video_memory, e);
        m_front = e;
        chk({name, "_ready"}, cmd_ready, 1'b1);
        chk({name, "_pending_drop"}, swap_pending, 1'b0);
    endtask

    initial begin
        int cnt;
        logic [N-1:0] e;

        tbl.push_back(mk(OP_WRITE, 3, 2, 1'b1, 1'b0, 0, 1'b1));
        tbl.push_back(mk(OP_FILL, 0, 0, 1'b0, 1'b0, H, 1'b1));
        tbl.push_back(mk(OP_CLEAR, 0, 0, 1'b0, 1'b0, H, 1'b1));
        for (int r = 0; r < H; r++) tbl.push_back(mk(OP_WRITE, 0, r, 1'b1, 1'b0, 0, 1'b0));
        tbl.push_back(mk(OP_SCROLL, 0, 0, 1'b0, 1'b0, H, 1'b1));
        tbl.push_back(mk(OP_WRITE, 10, 0, 1'b1, 1'b1, 0, 1'b0));
        tbl.push_back(mk(OP_WRITE, 0, 10, 1'b1, 1'b1, 0, 1'b1));
        tbl.push_back(mk(OP_NOP, 4, 4, 1'b1, 1'b0, 0, 1'b0));
        tbl.push_back(mk(3'd7, 4, 4, 1'b1, 1'b0, 0, 1'b1));
        tbl.push_back(mk(OP_WRITE, 9, 9, 1'b1, 1'b0, 0, 1'b0));
        tbl.push_back(mk(OP_COPY, 0, 0, 1'b0, 1'b0, H, 1'b0));
        tbl.push_back(mk(OP_WRITE, 5, 5, 1'b1, 1'b0, 0, 1'b1));

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_vm", video_memory, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pending", swap_pending, 1'b0);
        chk("rst_err", cmd_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1'b1);

        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].d);
            model_apply(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].d);
            chk($sformatf("v%0d_err", i), cmd_err, tbl[i].exp_err);
            cnt = 0;
            while (!cmd_ready && cnt < 50) begin
                cnt++;
                @(negedge clk);
            end
            chk($sformatf("v%0d_busy_cycles", i), N'(cnt), N'(tbl[i].exp_busy));
            @(negedge clk);
            chk($sformatf("v%0d_err_clear", i), cmd_err, 1'b0);
            if (tbl[i].swap) do_swap($sformatf("v%0d_swap", i));
            if (i == 0) begin
                e = '0; e[23] = 1'b1;
                chk("write_3_2_bit23", video_memory, e);
            end
            if (i == 13) begin
                e = '0;
                for (int r = 0; r < H - 1; r++) e[r*W] = 1'b1;
                chk("scroll_column", video_memory, e);
            end
        end

        // Back-to-back writes at one per cycle
        cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_x = 4'd2; cmd_y = 4'd7; cmd_data = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_ready", cmd_ready, 1'b1);
        model_apply(OP_WRITE, 4'd2, 4'd7, 1'b1);
        cmd_x = 4'd7; cmd_y = 4'd2;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        model_apply(OP_WRITE, 4'd7, 4'd2, 1'b1);
        chk("b2b_vm_unchanged", video_memory, m_front);
        do_swap("b2b_swap");

        // frame_start in the PRESENT acceptance cycle must not swap
        issue(OP_WRITE, 4'd1, 4'd1, 1'b1);
        model_apply(OP_WRITE, 4'd1, 4'd1, 1'b1);
        cmd_valid = 1'b1; cmd_op = OP_PRESENT; frame_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; frame_start = 1'b0;
        sb.push_back(m_back);
        chk("early_fs_noswap", video_memory, m_front);
        chk("early_fs_pending", swap_pending, 1'b1);
        repeat (4) @(negedge clk);
        chk("early_fs_still_waiting", cmd_ready, 1'b0);
        frame_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_start = 1'b0;
        e = sb.pop_front();
        chk("late_fs_swap", video_memory, e);
        m_front = e;
        chk("late_fs_ready", cmd_ready, 1'b1);

        // Reset in the middle of FILL at r=4
        issue(OP_FILL, 4'd0, 4'd0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_vm", video_memory, '0);
        chk("midrst_ready", cmd_ready, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_pending", swap_pending, 1'b0);
        chk("midrst_err", cmd_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", cmd_ready, 1'b1);
        m_back = '0; m_front = '0; sb.delete();
        do_swap("midrst_swap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
